// File: rtl/cas_pkg.sv
// Shared constants and types for the compare-and-swap sorting element.
package cas_pkg;
  localparam int unsigned ADDRW_DEF = 10;
  localparam int unsigned WL_DEF    = 32;
  localparam int unsigned SIGN_W    = 1;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 23;

  typedef struct packed {
    logic                 valid;
    logic [ADDRW_DEF-1:0] index;
    logic [WL_DEF-1:0]    value;
  } entry_t;

  function automatic logic is_nan(input logic [WL_DEF-1:0] x);
    return (x[WL_DEF-2 -: EXP_W] == '1) && (x[MAN_W-1:0] != '0);
  endfunction
endpackage

// File: rtl/cas_fp32_cmp.sv
// Combinational binary32 ordering: gt = (a > b), eq = (a == b).
// NaN ranks below every non-NaN, two NaNs compare equal, +0 equals -0.
module cas_fp32_cmp
  import cas_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        eq
);
  logic                    a_nan, b_nan, a_sgn, b_sgn;
  logic [EXP_W+MAN_W-1:0]  a_mag, b_mag;

  always_comb begin
    a_nan = is_nan(a);
    b_nan = is_nan(b);
    a_sgn = a[31];
    b_sgn = b[31];
    a_mag = a[EXP_W+MAN_W-1:0];
    b_mag = b[EXP_W+MAN_W-1:0];
    gt    = 1'b0;
    eq    = 1'b0;
    if (a_nan && b_nan) begin
      eq = 1'b1;
    end else if (a_nan) begin
      gt = 1'b0;
    end else if (b_nan) begin
      gt = 1'b1;
    end else if (a_mag == '0 && b_mag == '0) begin
      eq = 1'b1;
    end else if (a_sgn != b_sgn) begin
      gt = ~a_sgn;
    end else begin
      // Same sign: larger magnitude wins for positives, loses for negatives.
      eq = (a_mag == b_mag);
      gt = a_sgn ? (a_mag < b_mag) : (a_mag > b_mag);
    end
  end
endmodule

// File: rtl/cas.sv
// Registered compare-and-swap element; port 1 carries the winning entry.
// Build option: define CAS_ASCENDING_EN for ascending order (default descending).
module cas
  import cas_pkg::*;
#(
  parameter int unsigned ADDRW = ADDRW_DEF,
  parameter int unsigned WL    = WL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             valid1,
  input  logic             valid2,
  input  logic [ADDRW-1:0] index1,
  input  logic [ADDRW-1:0] index2,
  input  logic [WL-1:0]    value1,
  input  logic [WL-1:0]    value2,
  output logic             outvalid1,
  output logic             outvalid2,
  output logic [ADDRW-1:0] outindex1,
  output logic [ADDRW-1:0] outindex2,
  output logic [WL-1:0]    outvalue1,
  output logic [WL-1:0]    outvalue2
);
  typedef struct packed {
    logic             valid;
    logic [ADDRW-1:0] index;
    logic [WL-1:0]    value;
  } ent_t;

  ent_t e1, e2, o1, o2;
  logic gt21, eq21, better21, swap;

  cas_fp32_cmp u_cmp (
    .a  (value2),
    .b  (value1),
    .gt (gt21),
    .eq (eq21)
  );

  always_comb begin
    e1 = '{valid: valid1, index: index1, value: value1};
    e2 = '{valid: valid2, index: index2, value: value2};
`ifdef CAS_ASCENDING_EN
    // Comparator sinks NaN to the bottom; ascending needs it on top instead.
    if (is_nan(value1) && !is_nan(value2))
      better21 = 1'b1;
    else if (is_nan(value2))
      better21 = 1'b0;
    else
      better21 = !gt21 && !eq21;
`else
    better21 = gt21;
`endif
    swap = (valid2 && !valid1) ||
           (valid2 && valid1 && (better21 || (eq21 && (index2 < index1))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o1 <= '0;
      o2 <= '0;
    end else if (ena) begin
      o1 <= swap ? e2 : e1;
      o2 <= swap ? e1 : e2;
    end
  end

  always_comb begin
    outvalid1 = o1.valid;
    outindex1 = o1.index;
    outvalue1 = o1.value;
    outvalid2 = o2.valid;
    outindex2 = o2.index;
    outvalue2 = o2.value;
  end
endmodule

// File: tb/tb_cas.sv
// Self-checking bench for cas: directed cases plus random pairs against a
// real-number reference model.
module tb_cas;
  localparam int ADDRW = 10;
  localparam int WL    = 32;

  logic             clk = 1'b0;
  logic             rst, ena, valid1, valid2;
  logic [ADDRW-1:0] index1, index2;
  logic [WL-1:0]    value1, value2;
  logic             outvalid1, outvalid2;
  logic [ADDRW-1:0] outindex1, outindex2;
  logic [WL-1:0]    outvalue1, outvalue2;

  int tests  = 0;
  int failed = 0;

  logic             xv1, xv2;
  logic [ADDRW-1:0] xi1, xi2;
  logic [WL-1:0]    xx1, xx2;

  cas #(.ADDRW(ADDRW), .WL(WL)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .valid1(valid1), .valid2(valid2),
    .index1(index1), .index2(index2),
    .value1(value1), .value2(value2),
    .outvalid1(outvalid1), .outvalid2(outvalid2),
    .outindex1(outindex1), .outindex2(outindex2),
    .outvalue1(outvalue1), .outvalue2(outvalue2)
  );

  always #5 clk = ~clk;

  function automatic bit nan32(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic real f2r(logic [31:0] x);
    int  e;
    real m, r;
    e = int'(x[30:23]);
    m = real'(x[22:0]);
    if (e == 255)    r = 1.0e300;
    else if (e == 0) r = m * 2.0 ** (-149);
    else             r = (1.0 + m / 8388608.0) * 2.0 ** (e - 127);
    return x[31] ? -r : r;
  endfunction

  // Does entry A belong ahead of entry B?
  function automatic bit wins(logic va, logic [ADDRW-1:0] ia, logic [31:0] xa,
                              logic vb, logic [ADDRW-1:0] ib, logic [31:0] xb);
    real ra, rb;
    if (va != vb) return va;
    if (!va) return 1'b0;
    if (nan32(xa) && nan32(xb)) return ia < ib;
    if (nan32(xa)) return 1'b0;
    if (nan32(xb)) return 1'b1;
    ra = f2r(xa);
    rb = f2r(xb);
    if (ra == rb) return ia < ib;
`ifdef CAS_ASCENDING_EN
    return ra < rb;
`else
    return ra > rb;
`endif
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".v1"}, 64'(outvalid1), 64'(xv1));
    check({tag, ".v2"}, 64'(outvalid2), 64'(xv2));
    check({tag, ".i1"}, 64'(outindex1), 64'(xi1));
    check({tag, ".i2"}, 64'(outindex2), 64'(xi2));
    check({tag, ".x1"}, 64'(outvalue1), 64'(xx1));
    check({tag, ".x2"}, 64'(outvalue2), 64'(xx2));
  endtask

  // Drive one cycle and advance the expected output registers.
  task automatic step(logic r, logic en, logic v1, logic [ADDRW-1:0] i1, logic [31:0] x1,
                      logic v2, logic [ADDRW-1:0] i2, logic [31:0] x2);
    rst = r; ena = en;
    valid1 = v1; index1 = i1; value1 = x1;
    valid2 = v2; index2 = i2; value2 = x2;
    if (r) begin
      xv1 = 0; xv2 = 0; xi1 = 0; xi2 = 0; xx1 = 0; xx2 = 0;
    end else if (en) begin
      if (wins(v2, i2, x2, v1, i1, x1)) begin
        xv1 = v2; xi1 = i2; xx1 = x2; xv2 = v1; xi2 = i1; xx2 = x1;
      end else begin
        xv1 = v1; xi1 = i1; xx1 = x1; xv2 = v2; xi2 = i2; xx2 = x2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_value();
    logic [31:0] pool [10];
    pool = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000, 32'h80000000,
             32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h7F7FFFFF};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 9)];
    return $urandom;
  endfunction

  initial begin
    rst = 1; ena = 0; valid1 = 0; valid2 = 0;
    index1 = 0; index2 = 0; value1 = 0; value2 = 0;
    @(negedge clk);

    step(1, 0, 1, 10'd7, 32'h12345678, 1, 10'd9, 32'h3F800000);
    check_all("reset");
    check("reset.v1_const", 64'(outvalid1), 64'd0);
    step(0, 0, 1, 10'd7, 32'h12345678, 1, 10'd9, 32'h3F800000);
    check_all("reset_hold");

    step(0, 1, 1, 10'd1, 32'h3F800000, 1, 10'd0, 32'h3F800000);
    check("tie_a.i1", 64'(outindex1), 64'd0);
    check("tie_a.i2", 64'(outindex2), 64'd1);
    step(0, 1, 1, 10'd0, 32'h3F800000, 1, 10'd1, 32'h3F800000);
    check("tie_b.i1", 64'(outindex1), 64'd0);
    check_all("tie_b");

    step(0, 1, 1, 10'd5, 32'h3F800000, 1, 10'd6, 32'h40000000);
    check_all("mag_pos");
`ifdef CAS_ASCENDING_EN
    check("asc.x1", 64'(outvalue1), 64'h3F800000);
`else
    check("mag_pos.x1", 64'(outvalue1), 64'h40000000);
    check("mag_pos.i1", 64'(outindex1), 64'd6);
`endif
    step(0, 1, 1, 10'd5, 32'hBF800000, 1, 10'd6, 32'hC0000000);
    check_all("mag_neg");

    step(0, 1, 0, 10'd1, 32'h7F7FFFFF, 1, 10'd2, 32'h00000000);
    check("valid.v1", 64'(outvalid1), 64'd1);
    check("valid.x1", 64'(outvalue1), 64'h0);
    check("valid.v2", 64'(outvalid2), 64'd0);

    step(0, 1, 1, 10'd3, 32'h00000000, 1, 10'd2, 32'h80000000);
    check("zero.i1", 64'(outindex1), 64'd2);
    step(0, 1, 1, 10'd4, 32'h7FC00000, 1, 10'd8, 32'hFF800000);
    check("nan.x1", 64'(outvalue1), 64'hFF800000);
    check_all("nan");
    step(0, 1, 0, 10'd4, 32'h3F800000, 0, 10'd2, 32'h40000000);
    check_all("both_invalid");

    step(0, 1, 1, 10'd11, 32'h41200000, 1, 10'd12, 32'hC1200000);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, $urandom_range(0, 1), 10'($urandom), $urandom,
           $urandom_range(0, 1), 10'($urandom), $urandom);
      check_all("hold");
    end

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 3) != 0), 10'($urandom_range(0, 3)), pick_value(),
           ($urandom_range(0, 3) != 0), 10'($urandom_range(0, 3)), pick_value());
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/cas.md
# cas

Registered compare-and-swap element for the hardware sorting/top-k network. Each cycle it takes two (valid, index, value) entries with IEEE-754 single-precision values and emits them ordered so that port 1 holds the "winner". It is the basic building block replicated across every stage of the network.

## Interface
- ADDRW, 10, index width in bits
- WL, 32, value width; only 32 (IEEE-754 binary32) is supported
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- ena  input  1  register enable; when low all outputs hold
- valid1, valid2  input  1  entry valid flags
- index1, index2  input  ADDRW  entry indices
- value1, value2  input  WL  entry values (binary32)
- outvalid1, outvalid2  output  1  ordered valid flags
- outindex1, outindex2  output  ADDRW  ordered indices
- outvalue1, outvalue2  output  WL  ordered values

## Operation
- Combinational decision `swap`; output pair = swap ? (entry2, entry1) : (entry1, entry2); valid, index, value always move together.
- Default order descending: entry A precedes B (A "wins") when:
  - A valid and B invalid; or
  - both valid and value(A) > value(B) under float order; or
  - both valid, values equal, index(A) < index(B).
- Both invalid: no swap.
- Float order: sign-magnitude comparison; +0 and -0 equal; NaN (exp all ones, mantissa nonzero) ranks below every non-NaN; two NaNs equal (index tie-break applies). ±Inf ordinary extremes.
- swap = entry2 wins over entry1; equal entries with equal index: no swap.
- Pure comparison; no arithmetic, values pass bit-exact.

## Timing
- Latency 1 cycle: outputs registered on rising clk when ena=1.
- ena=0: all outputs hold previous values; inputs ignored.
- rst=1 at a clock edge: all outputs cleared to 0 (outvalid1/2=0, indices 0, values 0); rst has priority over ena.
- Full throughput: one pair accepted per enabled cycle, no handshake/backpressure beyond ena.
- Output registers not otherwise initialised; before first reset, outputs are undefined.

## Configuration
- CAS_ASCENDING_EN: defined -> ascending order (smaller value wins port 1; ties still smaller index first; invalid still last; NaN ranks above all non-NaN so it still sinks to port 2). Undefined -> descending order as above.

## Structure
- Package cas_pkg: default ADDRW/WL constants, binary32 field widths (sign 1, exp 8, mantissa 23), packed entry typedef {valid, index, value}.
- One sub-module natural: cas_fp32_cmp, combinational, outputs gt/eq for two binary32 operands with the NaN/zero rules above; cas instantiates it once.

## Test plan
- Reset: rst=1 one cycle -> all outputs 0; ena=0 thereafter -> outputs stay 0 regardless of inputs.
- Equal values tie-break: both valid, value 0x3F800000 (1.0), index1=1, index2=0 with ena=1 -> next cycle outindex1=0, outindex2=1; swap inputs index1=0, index2=1 -> outindex1=0, outindex2=1.
- Magnitude: value1=0x3F800000 (1.0), value2=0x40000000 (2.0), idx 5/6 -> outvalue1=0x40000000, outindex1=6; negatives value1=0xBF800000 (-1.0), value2=0xC0000000 (-2.0) -> outvalue1=0xBF800000.
- Validity: valid1=0, valid2=1, value1=0x7F7FFFFF, value2=0x00000000 -> outvalid1=1, outvalue1=0x00000000, outvalid2=0.
- Specials: +0 vs -0 (0x00000000/0x80000000) idx 3/2 -> outindex1=2; NaN 0x7FC00000 vs 0xFF800000 (-Inf) -> outvalue1=0xFF800000.
- Hold: load a pair, drop ena, change inputs 3 cycles -> outputs unchanged; with CAS_ASCENDING_EN defined, 1.0 vs 2.0 -> outvalue1=0x3F800000.
